// File: rtl/lb_app_mailbox_pkg.sv
// Shared constants for the application-window mailbox: window decode, register
// indices and status-word bit positions.
package lb_app_mailbox_pkg;

   localparam logic [7:0]  LB_WINDOW        = 8'h18;
   localparam logic [31:0] BLOCK_ID_DEFAULT = 32'h4d42_0001;

   localparam logic [2:0] REG_ID      = 3'd0;
   localparam logic [2:0] REG_SCRATCH = 3'd1;
   localparam logic [2:0] REG_STATUS  = 3'd2;
   localparam logic [2:0] REG_FIFO    = 3'd3;
   localparam logic [2:0] REG_TSTAMP  = 3'd4;

   localparam int ST_H2A_LVL_LSB = 0;
   localparam int ST_A2H_LVL_LSB = 8;
   localparam int ST_H2A_OVF     = 16;
   localparam int ST_A2H_OVF     = 17;
   localparam int ST_A2H_UNF     = 18;
   localparam int ST_IRQ_EN      = 24;

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous first-word-fall-through FIFO with level count, full/empty and an
// overflow pulse for a push that had to be dropped.
module mbox_fifo #(
   parameter int W  = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty,
   output logic          overflow
);

   localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop_ok;
   logic          push_ok;

   assign empty    = (level == '0);
   assign full     = (level == DEPTH);
   assign head     = mem[rd_ptr];

   // A pop frees a slot in the same cycle, so a push onto a full FIFO that is
   // also being popped still lands.
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign overflow = push & ~push_ok;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/lb_app_mailbox.sv
// Application-window local-bus responder: ID/scratch/status registers plus the
// H2A and A2H mailbox FIFOs. Build macro LB_APP_MAILBOX_TIMESTAMP_EN adds register 4.
module lb_app_mailbox
   import lb_app_mailbox_pkg::*;
#(
   parameter int          FIFO_AW  = 4,
   parameter logic [31:0] BLOCK_ID = BLOCK_ID_DEFAULT
) (
   input  logic        lb_clk,
   input  logic        rstn,
   input  logic [23:0] lb_addr,
   input  logic        lb_strobe,
   input  logic        lb_rd,
   input  logic        lb_write,
   input  logic [31:0] lb_data_out,
   output logic [31:0] lb_data_in,
   output logic [31:0] h2a_data,
   output logic        h2a_valid,
   input  logic        h2a_ready,
   input  logic [31:0] a2h_data,
   input  logic        a2h_push,
   output logic        a2h_full,
   output logic        irq
);

   logic             sel;
   logic [2:0]       idx;
   logic             rd_req;
   logic             wr_req;
   logic             stat_wr;
   logic             h2a_push;
   logic             h2a_pop;
   logic             a2h_pop_req;
   logic             a2h_unf_pulse;
   logic [31:0]      h2a_head;
   logic [31:0]      a2h_head;
   logic [FIFO_AW:0] h2a_level;
   logic [FIFO_AW:0] a2h_level;
   logic             h2a_empty;
   logic             a2h_empty;
   logic             h2a_full_unused;
   logic             h2a_ovf_pulse;
   logic             a2h_ovf_pulse;
   logic [12:0]      addr_unused;

   logic [31:0]      scratch;
   logic             irq_en;
   logic             h2a_ovf;
   logic             a2h_ovf;
   logic             a2h_unf;
   logic [31:0]      status_word;
   logic [31:0]      tstamp_word;

   logic             rd_pend;
   logic [2:0]       rd_idx;
   logic [31:0]      rd_fifo_word;
   logic [31:0]      rd_mux;

   assign sel         = (lb_addr[23:16] == LB_WINDOW);
   assign idx         = lb_addr[2:0];
   assign addr_unused = lb_addr[15:3];
   assign rd_req      = lb_strobe & lb_rd & sel;
   assign wr_req      = lb_write & sel;
   assign stat_wr     = wr_req & (idx == REG_STATUS);

   assign h2a_push      = wr_req & (idx == REG_FIFO);
   assign a2h_pop_req   = rd_req & (idx == REG_FIFO);
   assign a2h_unf_pulse = a2h_pop_req & a2h_empty;

   // H2A stream: h2a_data is meaningful whenever h2a_valid is high, and a word
   // transfers on every clock where h2a_valid and h2a_ready are both high;
   // valid never depends on ready.
   assign h2a_pop   = h2a_valid & h2a_ready;
   assign h2a_valid = ~h2a_empty;
   assign h2a_data  = h2a_valid ? h2a_head : '0;
   assign irq       = irq_en & ~a2h_empty;

   mbox_fifo #(.W(32), .AW(FIFO_AW)) u_h2a (
      .clk       (lb_clk),
      .rstn      (rstn),
      .push      (h2a_push),
      .push_data (lb_data_out),
      .pop       (h2a_pop),
      .head      (h2a_head),
      .level     (h2a_level),
      .full      (h2a_full_unused),
      .empty     (h2a_empty),
      .overflow  (h2a_ovf_pulse)
   );

   mbox_fifo #(.W(32), .AW(FIFO_AW)) u_a2h (
      .clk       (lb_clk),
      .rstn      (rstn),
      .push      (a2h_push),
      .push_data (a2h_data),
      .pop       (a2h_pop_req),
      .head      (a2h_head),
      .level     (a2h_level),
      .full      (a2h_full),
      .empty     (a2h_empty),
      .overflow  (a2h_ovf_pulse)
   );

   // Sticky flags: a set arriving in the same cycle as a host clear survives.
   always_ff @(posedge lb_clk or negedge rstn) begin
      if (!rstn) begin
         scratch <= '0;
         irq_en  <= 1'b0;
         h2a_ovf <= 1'b0;
         a2h_ovf <= 1'b0;
         a2h_unf <= 1'b0;
      end else begin
         if (wr_req && (idx == REG_SCRATCH)) scratch <= lb_data_out;
         if (stat_wr) irq_en <= lb_data_out[ST_IRQ_EN];
         h2a_ovf <= (h2a_ovf & ~(stat_wr & lb_data_out[ST_H2A_OVF])) | h2a_ovf_pulse;
         a2h_ovf <= (a2h_ovf & ~(stat_wr & lb_data_out[ST_A2H_OVF])) | a2h_ovf_pulse;
         a2h_unf <= (a2h_unf & ~(stat_wr & lb_data_out[ST_A2H_UNF])) | a2h_unf_pulse;
      end
   end

   always_comb begin
      status_word = '0;
      status_word[ST_H2A_LVL_LSB +: FIFO_AW+1] = h2a_level;
      status_word[ST_A2H_LVL_LSB +: FIFO_AW+1] = a2h_level;
      status_word[ST_H2A_OVF] = h2a_ovf;
      status_word[ST_A2H_OVF] = a2h_ovf;
      status_word[ST_A2H_UNF] = a2h_unf;
      status_word[ST_IRQ_EN]  = irq_en;
   end

`ifdef LB_APP_MAILBOX_TIMESTAMP_EN
   logic [31:0] ts_count;
   logic [31:0] ts_shadow;

   always_ff @(posedge lb_clk or negedge rstn) begin
      if (!rstn) begin
         ts_count  <= '0;
         ts_shadow <= '0;
      end else begin
         ts_count <= ts_count + 32'd1;
         if (a2h_push) ts_shadow <= ts_count;
      end
   end

   assign tstamp_word = ts_shadow;
`else
   assign tstamp_word = '0;
`endif

   // The A2H word is captured at the strobe cycle because that is when the pop
   // commits; everything else is muxed one cycle later from live registers.
   always_ff @(posedge lb_clk or negedge rstn) begin
      if (!rstn) begin
         rd_pend      <= 1'b0;
         rd_idx       <= '0;
         rd_fifo_word <= '0;
      end else begin
         rd_pend      <= rd_req;
         rd_idx       <= idx;
         rd_fifo_word <= a2h_empty ? '0 : a2h_head;
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (rd_idx)
         REG_ID:      rd_mux = BLOCK_ID;
         REG_SCRATCH: rd_mux = scratch;
         REG_STATUS:  rd_mux = status_word;
         REG_FIFO:    rd_mux = rd_fifo_word;
         REG_TSTAMP:  rd_mux = tstamp_word;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge lb_clk or negedge rstn) begin
      if (!rstn) begin
         lb_data_in <= '0;
      end else if (rd_pend) begin
         lb_data_in <= rd_mux;
      end
   end

endmodule
